// File: rtl/ascon_op_scheduler.sv
// ascon_op_scheduler: front-end controller for the serial Ascon core.
// Arbitrates two requesters round-robin, then for the owner: resets the core,
// paces the serial operand load, starts enc/dec, waits for ready (with timeout),
// paces the serial result drain and returns a done/status pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req[1:0], op[1:0]        per-requester request / op select (0=enc, 1=dec)
//   grant[1:0], busy         one-hot core owner, controller active
//   core_rst, shift_en       core sync reset, operand load strobe
//   enc_start, dec_start     core start handshakes (held RUN..DRAIN)
//   core_enc_ready, core_dec_ready, core_auth   core status inputs
//   out_valid, bit_idx[7:0]  serial result bit qualifier and index
//   done[1:0], auth_fail, timeout_err           completion pulse and status
module ascon_op_scheduler #(
    parameter int unsigned K        = 128,
    parameter int unsigned L        = 80,
    parameter int unsigned Y        = 80,
    parameter int unsigned OUT_BITS = 128,
    parameter int unsigned TIMEOUT  = 16383
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] op,
    output logic [1:0] grant,
    output logic       busy,
    output logic       core_rst,
    output logic       shift_en,
    output logic       enc_start,
    output logic       dec_start,
    input  logic       core_enc_ready,
    input  logic       core_dec_ready,
    input  logic       core_auth,
    output logic       out_valid,
    output logic [7:0] bit_idx,
    output logic [1:0] done,
    output logic       auth_fail,
    output logic       timeout_err
);

    // Load length is the longest core operand, never shorter than 128
    localparam int unsigned MAX_KL = (K > L) ? K : L;
    localparam int unsigned MAX_KLY = (MAX_KL > Y) ? MAX_KL : Y;
    localparam int unsigned MAXLEN = (MAX_KLY > 128) ? MAX_KLY : 128;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W = 16;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(MAXLEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(OUT_BITS - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic              r_core_rst;
    logic              r_shift_en;
    logic              r_enc_start;
    logic              r_dec_start;
    logic              r_out_valid;
    logic [7:0]        r_bit_idx;
    logic [1:0]        r_done;
    logic              r_auth_fail;
    logic              r_timeout_err;
    logic              r_op;
    logic              r_rr;
    logic              r_auth;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_tcnt;

    logic              w_win;
    logic              w_ready;
    logic              w_auth;

    // On a tie the requester that did not win last time is served
    assign w_win   = (req == 2'b11) ? ~r_rr : req[1];
    assign w_ready = r_op ? core_dec_ready : core_enc_ready;
    // Tag status is taken on the first drain cycle; bypass covers OUT_BITS==1
    assign w_auth  = (r_cnt == '0) ? (r_op & ~core_auth) : r_auth;

    // Operation sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_core_rst    <= 1'b1;
            r_shift_en    <= 1'b0;
            r_enc_start   <= 1'b0;
            r_dec_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_bit_idx     <= '0;
            r_done        <= 2'b00;
            r_auth_fail   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_op          <= 1'b0;
            r_rr          <= 1'b1;
            r_auth        <= 1'b0;
            r_cnt         <= '0;
            r_tcnt        <= '0;
        end else begin
            r_done        <= 2'b00;
            r_auth_fail   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_core_rst <= 1'b0;
                    if (|req) begin
                        r_op       <= op[w_win];
                        r_rr       <= w_win;
                        r_grant    <= w_win ? 2'b10 : 2'b01;
                        r_busy     <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_state    <= S_CRST;
                    end
                end
                S_CRST: begin
                    r_core_rst <= 1'b0;
                    r_shift_en <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_cnt == LOAD_LAST) begin
                        r_shift_en <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    r_enc_start <= ~r_op;
                    r_dec_start <= r_op;
                    r_tcnt      <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    // Ready is checked before the timeout so it wins a tie
                    if (w_ready) begin
                        r_out_valid <= 1'b1;
                        r_bit_idx   <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_DRAIN;
                    end else if (r_tcnt == TO_LAST) begin
                        r_enc_start   <= 1'b0;
                        r_dec_start   <= 1'b0;
                        r_done        <= r_grant;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_auth <= r_op & ~core_auth;
                    end
                    if (r_cnt == DRAIN_LAST) begin
                        r_out_valid <= 1'b0;
                        r_bit_idx   <= '0;
                        r_enc_start <= 1'b0;
                        r_dec_start <= 1'b0;
                        r_done      <= r_grant;
                        r_auth_fail <= w_auth;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_bit_idx <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign core_rst    = r_core_rst;
    assign shift_en    = r_shift_en;
    assign enc_start   = r_enc_start;
    assign dec_start   = r_dec_start;
    assign out_valid   = r_out_valid;
    assign bit_idx     = r_bit_idx;
    assign done        = r_done;
    assign auth_fail   = r_auth_fail;
    assign timeout_err = r_timeout_err;

endmodule
